// File: rtl/tqvp_cntbank_pkg.sv
// Shared constants for the PRISM counter bank: register addresses, CTRL/STATUS
// bit offsets and the maximum number of counters the register map can describe.
package tqvp_cntbank_pkg;

    // Register addresses within the 64-byte window
    localparam logic [5:0] CTRL_ADDR     = 6'h00;
    localparam logic [5:0] STATUS_ADDR   = 6'h04;
    localparam logic [5:0] MASK_ADDR     = 6'h08;
    localparam logic [5:0] PRESCALE_ADDR = 6'h0C;
    localparam logic [5:0] PRELOAD_BASE  = 6'h10;
    localparam logic [5:0] COUNT_BASE    = 6'h20;

    // Bit offsets inside CTRL / STATUS / MASK
    localparam int EN_LSB   = 0;
    localparam int AR_LSB   = 8;
    localparam int HALT_BIT = 8;

    // The map reserves room for four counters
    localparam int MAX_CNT = 4;

    // Address of the idx-th word of a per-counter register array
    function automatic logic [5:0] reg_addr(input logic [5:0] base, input int unsigned idx);
        return base + 6'(idx * 4);
    endfunction

endpackage

// File: rtl/tqvp_cntbank_chan.sv
// One down-counter channel of the PRISM counter bank: holds the preload and the
// count, applies the SW-write / load / auto-reload / decrement priority, and
// flags the cycle in which a decrement takes the count from 1 to 0.
module tqvp_cntbank_chan
    import tqvp_cntbank_pkg::*;
#(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             act,
    input  logic             tick,
    input  logic             ar,
    input  logic             dec,
    input  logic             load,
    input  logic             count_wr,
    input  logic             preload_wr,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] preload,
    output logic             zero,
    output logic             zero_evt
);

    logic reload_now;
    logic dec_now;

    // Decode which hardware action would apply this cycle
    always_comb begin
        reload_now = act && (load || (ar && (count == '0)));
        dec_now    = act && dec && tick && (count != '0);
        // The event only fires if nothing of higher priority overrides the decrement
        zero_evt   = !count_wr && !reload_now && dec_now && (count == CNT_W'(1));
    end

    // Preload register, only changed by software
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preload <= '0;
        end else if (preload_wr) begin
            preload <= wdata;
        end
    end

    // Count register: SW write, then load/auto-reload, then saturating decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count_wr) begin
            count <= wdata;
        end else if (reload_now) begin
            count <= preload;
        end else if (dec_now) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tqvp_prism_cntbank.sv
// PRISM counter bank top: TinyQV register decode, CTRL/STATUS/MASK, halt edge
// detect, optional prescaler and the read mux around NUM_CNT counter channels.
// Optional feature: define TQVP_CNTBANK_PRESCALE_EN to add the PRESCALE register
// and the shared tick divider; otherwise every cycle is a tick.
module tqvp_prism_cntbank
    import tqvp_cntbank_pkg::*;
#(
    parameter int NUM_CNT = 2,
    parameter int CNT_W   = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         address,
    input  logic [31:0]        data_in,
    input  logic [1:0]         data_write_n,
    input  logic [1:0]         data_read_n,
    output logic [31:0]        data_out,
    output logic               data_ready,
    input  logic               fsm_halt,
    input  logic [NUM_CNT-1:0] cnt_dec,
    input  logic [NUM_CNT-1:0] cnt_load,
    output logic [NUM_CNT-1:0] cnt_zero,
    output logic               user_interrupt
);

    logic               wr;
    logic               ctrl_wr;
    logic               status_wr;
    logic               mask_wr;

    logic [NUM_CNT-1:0] en;
    logic [NUM_CNT-1:0] ar;
    logic [NUM_CNT-1:0] zero_st;
    logic               halt_st;
    logic [NUM_CNT-1:0] mask_zero;
    logic               mask_halt;
    logic               halt_q;
    logic               halt_rise;
    logic [NUM_CNT-1:0] zero_clr;
    logic               halt_clr;

    logic [NUM_CNT-1:0] count_wr;
    logic [NUM_CNT-1:0] preload_wr;
    logic [NUM_CNT-1:0] zero_evt;
    logic [CNT_W-1:0]   count_vals   [NUM_CNT];
    logic [CNT_W-1:0]   preload_vals [NUM_CNT];

    logic               tick;
    logic               unused_bits;

    // Reads never have side effects, so the read strobe is not needed
    assign unused_bits = &{1'b0, data_read_n, data_in};
    assign data_ready  = 1'b1;

    assign wr        = (data_write_n == 2'b10);
    assign ctrl_wr   = wr && (address == CTRL_ADDR);
    assign status_wr = wr && (address == STATUS_ADDR);
    assign mask_wr   = wr && (address == MASK_ADDR);
    assign halt_rise = fsm_halt && !halt_q;

`ifdef TQVP_CNTBANK_PRESCALE_EN
    logic       prescale_wr;
    logic [7:0] prescale;
    logic [7:0] div_cnt;

    assign prescale_wr = wr && (address == PRESCALE_ADDR);

    // Shared divider: reloads from PRESCALE after reaching 0, paused while halted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            div_cnt  <= '0;
        end else if (prescale_wr) begin
            prescale <= data_in[7:0];
            div_cnt  <= data_in[7:0];
        end else if (!fsm_halt) begin
            div_cnt <= (div_cnt == 8'd0) ? prescale : div_cnt - 8'd1;
        end
    end

    assign tick = (div_cnt == 8'd0);
`else
    assign tick = 1'b1;
`endif

    // Counter channels with their register write strobes
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_chan
        assign count_wr[g]   = wr && (address == reg_addr(COUNT_BASE, g));
        assign preload_wr[g] = wr && (address == reg_addr(PRELOAD_BASE, g));

        tqvp_cntbank_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .act        (en[g] && !fsm_halt),
            .tick       (tick),
            .ar         (ar[g]),
            .dec        (cnt_dec[g]),
            .load       (cnt_load[g]),
            .count_wr   (count_wr[g]),
            .preload_wr (preload_wr[g]),
            .wdata      (data_in[CNT_W-1:0]),
            .count      (count_vals[g]),
            .preload    (preload_vals[g]),
            .zero       (cnt_zero[g]),
            .zero_evt   (zero_evt[g])
        );
    end

    // Previous halt level for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= fsm_halt;
        end
    end

    // CTRL: per-counter enable and auto-reload bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en <= '0;
            ar <= '0;
        end else if (ctrl_wr) begin
            en <= data_in[EN_LSB +: NUM_CNT];
            ar <= data_in[AR_LSB +: NUM_CNT];
        end
    end

    // W1C clear masks for STATUS
    always_comb begin
        zero_clr = '0;
        halt_clr = 1'b0;
        if (status_wr) begin
            zero_clr = data_in[EN_LSB +: NUM_CNT];
            halt_clr = data_in[HALT_BIT];
        end
    end

    // STATUS: sticky events, a hardware set beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_st <= '0;
            halt_st <= 1'b0;
        end else begin
            zero_st <= (zero_st & ~zero_clr) | zero_evt;
            halt_st <= (halt_st & ~halt_clr) | halt_rise;
        end
    end

    // MASK: interrupt enables, same layout as STATUS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_zero <= '0;
            mask_halt <= 1'b0;
        end else if (mask_wr) begin
            mask_zero <= data_in[EN_LSB +: NUM_CNT];
            mask_halt <= data_in[HALT_BIT];
        end
    end

    assign user_interrupt = |(zero_st & mask_zero) || (halt_st && mask_halt);

    // Read mux: unmapped addresses and unimplemented bits read as zero
    always_comb begin
        data_out = '0;
        if (address == CTRL_ADDR) begin
            data_out[EN_LSB +: NUM_CNT] = en;
            data_out[AR_LSB +: NUM_CNT] = ar;
        end else if (address == STATUS_ADDR) begin
            data_out[EN_LSB +: NUM_CNT] = zero_st;
            data_out[HALT_BIT]          = halt_st;
        end else if (address == MASK_ADDR) begin
            data_out[EN_LSB +: NUM_CNT] = mask_zero;
            data_out[HALT_BIT]          = mask_halt;
        end
`ifdef TQVP_CNTBANK_PRESCALE_EN
        if (address == PRESCALE_ADDR) begin
            data_out[7:0] = prescale;
        end
`endif
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (address == reg_addr(PRELOAD_BASE, i)) begin
                data_out = 32'(preload_vals[i]);
            end
            if (address == reg_addr(COUNT_BASE, i)) begin
                data_out = 32'(count_vals[i]);
            end
        end
    end

endmodule

// File: tb/tb_tqvp_prism_cntbank.sv
// Self-checking bench for tqvp_prism_cntbank: directed steps followed by random
// traffic, all compared against a behavioural model of the register map.
module tb_tqvp_prism_cntbank;

    localparam int          NUM_CNT = 2;
    localparam int          CNT_W   = 28;
    localparam logic [31:0] CMASK   = 32'h0FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        fsm_halt;
    logic [1:0]  cnt_dec;
    logic [1:0]  cnt_load;
    logic [1:0]  cnt_zero;
    logic        user_interrupt;

    always #5 clk = ~clk;

    tqvp_prism_cntbank #(
        .NUM_CNT(NUM_CNT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (address),
        .data_in       (data_in),
        .data_write_n  (data_write_n),
        .data_read_n   (data_read_n),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .fsm_halt      (fsm_halt),
        .cnt_dec       (cnt_dec),
        .cnt_load      (cnt_load),
        .cnt_zero      (cnt_zero),
        .user_interrupt(user_interrupt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_cnt [4];
    int unsigned m_pre [4];
    logic        m_en  [4];
    logic        m_ar  [4];
    logic [31:0] m_st;
    logic [31:0] m_mask;
    logic        m_halt_prev;
`ifdef TQVP_CNTBANK_PRESCALE_EN
    int unsigned m_prescale;
    int unsigned m_div;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [5:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a == 6'h00) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (m_en[i]) r = r | (32'h1 << i);
                if (m_ar[i]) r = r | (32'h100 << i);
            end
        end else if (a == 6'h04) begin
            r = m_st;
        end else if (a == 6'h08) begin
            r = m_mask;
        end
`ifdef TQVP_CNTBANK_PRESCALE_EN
        if (a == 6'h0C) r = m_prescale;
`endif
        for (int i = 0; i < NUM_CNT; i++) begin
            if (a == 6'(16 + 4 * i)) r = m_pre[i];
            if (a == 6'(32 + 4 * i)) r = m_cnt[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] m_zero();
        logic [31:0] z;
        z = 32'h0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (m_cnt[i] == 0) z = z | (32'h1 << i);
        end
        return z;
    endfunction

    function automatic logic [31:0] m_irq();
        return ((m_st & m_mask) != 32'h0) ? 32'h1 : 32'h0;
    endfunction

    // Advance one clock: model computes its next state from the driven inputs
    task automatic cycle();
        int unsigned n_cnt [4];
        int unsigned n_pre [4];
        logic [31:0] set;
        logic        wr;
        logic        act;
        logic        tick;
        wr    = (data_write_n == 2'b10);
        set   = 32'h0;
        n_cnt = m_cnt;
        n_pre = m_pre;
`ifdef TQVP_CNTBANK_PRESCALE_EN
        tick = (m_div == 0);
`else
        tick = 1'b1;
`endif
        for (int i = 0; i < NUM_CNT; i++) begin
            act = m_en[i] && !fsm_halt;
            if (wr && address == 6'(32 + 4 * i)) begin
                n_cnt[i] = data_in & CMASK;
            end else if (act && cnt_load[i]) begin
                n_cnt[i] = m_pre[i];
            end else if (act && m_ar[i] && m_cnt[i] == 0) begin
                n_cnt[i] = m_pre[i];
            end else if (act && cnt_dec[i] && tick && m_cnt[i] != 0) begin
                n_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 1) set = set | (32'h1 << i);
            end
            if (wr && address == 6'(16 + 4 * i)) n_pre[i] = data_in & CMASK;
        end
        if (fsm_halt && !m_halt_prev) set = set | 32'h100;
        @(posedge clk);
        #1;
        m_cnt = n_cnt;
        m_pre = n_pre;
        m_st  = ((wr && address == 6'h04) ? (m_st & ~data_in) : m_st) | set;
        if (wr && address == 6'h08) m_mask = data_in & (32'h100 | ((32'h1 << NUM_CNT) - 1));
        if (wr && address == 6'h00) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                m_en[i] = data_in[i];
                m_ar[i] = data_in[8 + i];
            end
        end
`ifdef TQVP_CNTBANK_PRESCALE_EN
        if (wr && address == 6'h0C) begin
            m_prescale = data_in & 32'hFF;
            m_div      = m_prescale;
        end else if (!fsm_halt) begin
            m_div = (m_div == 0) ? m_prescale : m_div - 1;
        end
`endif
        m_halt_prev = fsm_halt;
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
        address      = a;
        data_in      = d;
        data_write_n = 2'b10;
        cycle();
        data_write_n = 2'b11;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    logic [5:0]  addr_list [11] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14,
                                    6'h18, 6'h20, 6'h24, 6'h2C, 6'h30};
    int          seq_ar    [6]  = '{1, 0, 2, 1, 0, 2};

    initial begin
        rst_n        = 1'b0;
        address      = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        fsm_halt     = 1'b0;
        cnt_dec      = '0;
        cnt_load     = '0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
            m_en[i]  = 1'b0;
            m_ar[i]  = 1'b0;
        end
        m_st        = '0;
        m_mask      = '0;
        m_halt_prev = 1'b0;
`ifdef TQVP_CNTBANK_PRESCALE_EN
        m_prescale = 0;
        m_div      = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        chk("reset_cnt_zero", 32'(cnt_zero), 32'h3);
        chk("reset_irq", 32'(user_interrupt), 32'h0);
        chk("reset_ready", 32'(data_ready), 32'h1);
        for (int a = 0; a <= 44; a += 4) begin
            rd($sformatf("reset_rd_%0h", a), 6'(a), 32'h0);
            cycle();
        end

        // One-shot countdown 3,2,1,0
        bus_wr(6'h10, 32'd3);
        bus_wr(6'h00, 32'h1);
        cnt_load = 2'b01;
        cycle();
        cnt_load = 2'b00;
        rd("os_cnt_3", 6'h20, 32'd3);
        cnt_dec = 2'b01;
        for (int k = 2; k >= 0; k--) begin
            cycle();
            rd($sformatf("os_cnt_%0d", k), 6'h20, 32'(k));
        end
        chk("os_zero_rise", 32'(cnt_zero[0]), 32'h1);
        cycle();
        cycle();
        rd("os_saturate", 6'h20, 32'd0);
        chk("os_zero_hold", 32'(cnt_zero[0]), 32'h1);
        cnt_dec = 2'b00;
        rd("os_status", 6'h04, 32'h1);
        bus_wr(6'h08, 32'h1);
        chk("os_irq_set", 32'(user_interrupt), 32'h1);
        bus_wr(6'h04, 32'h1);
        rd("os_status_clr", 6'h04, 32'h0);
        chk("os_irq_clr", 32'(user_interrupt), 32'h0);

        // Auto-reload 2,1,0,2,1,0
        bus_wr(6'h00, 32'h101);
        bus_wr(6'h10, 32'd2);
        cnt_load = 2'b01;
        cycle();
        cnt_load = 2'b00;
        rd("ar_cnt_start", 6'h20, 32'd2);
        cnt_dec = 2'b01;
        for (int k = 0; k < 6; k++) begin
            cycle();
            rd($sformatf("ar_cnt_%0d", k), 6'h20, 32'(seq_ar[k]));
            chk($sformatf("ar_zero_%0d", k), 32'(cnt_zero[0]), (seq_ar[k] == 0) ? 32'h1 : 32'h0);
        end
        cnt_dec = 2'b00;
        bus_wr(6'h00, 32'h0);
        bus_wr(6'h04, 32'h1FF);

        // Halt freezes the count; halt edge is sticky and beats a W1C
        bus_wr(6'h00, 32'h1);
        bus_wr(6'h10, 32'd5);
        cnt_load = 2'b01;
        cycle();
        cnt_load = 2'b00;
        cnt_dec  = 2'b01;
        cycle();
        cycle();
        fsm_halt = 1'b1;
        cycle();
        cycle();
        cycle();
        rd("halt_frozen", 6'h20, 32'd3);
        rd("halt_status", 6'h04, 32'h100);
        bus_wr(6'h04, 32'h100);
        cycle();
        rd("halt_once", 6'h04, 32'h0);
        fsm_halt = 1'b0;
        cycle();
        rd("halt_resume", 6'h20, 32'd2);
        fsm_halt = 1'b1;
        bus_wr(6'h04, 32'h100);
        rd("halt_set_wins", 6'h04, 32'h100);
        rd("halt_frozen2", 6'h20, 32'd2);
        fsm_halt = 1'b0;
        cnt_dec  = 2'b00;
        bus_wr(6'h00, 32'h0);
        bus_wr(6'h04, 32'h1FF);

        // SW write to COUNT1 beats load and decrement; writing 0 sets no event
        bus_wr(6'h00, 32'h3);
        bus_wr(6'h14, 32'd9);
        cnt_load = 2'b10;
        cnt_dec  = 2'b10;
        bus_wr(6'h24, 32'd5);
        cnt_load = 2'b00;
        cnt_dec  = 2'b00;
        rd("c1_sw_wins", 6'h24, 32'd5);
        bus_wr(6'h24, 32'd0);
        rd("c1_write0", 6'h24, 32'd0);
        rd("c1_no_event", 6'h04, 32'h0);
        chk("c1_zero", 32'(cnt_zero[1]), 32'h1);
        bus_wr(6'h00, 32'h0);

`ifdef TQVP_CNTBANK_PRESCALE_EN
        // Prescaler: one decrement every PRESCALE+1 cycles
        begin
            int          chg [$];
            logic [31:0] prev;
            bus_wr(6'h0C, 32'd3);
            rd("ps_reg", 6'h0C, 32'd3);
            bus_wr(6'h10, 32'd2);
            bus_wr(6'h00, 32'h1);
            cnt_load = 2'b01;
            cycle();
            cnt_load = 2'b00;
            cnt_dec  = 2'b01;
            address  = 6'h20;
            #1;
            prev = data_out;
            for (int c = 0; c < 12; c++) begin
                cycle();
                if (data_out != prev) chg.push_back(c);
                prev = data_out;
            end
            chk("ps_ndec", 32'(chg.size()), 32'd2);
            if (chg.size() == 2) chk("ps_gap", 32'(chg[1] - chg[0]), 32'd4);
            cnt_dec = 2'b00;
            bus_wr(6'h0C, 32'd0);
            bus_wr(6'h00, 32'h0);
        end
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            fsm_halt = ($urandom_range(9) < 2);
            cnt_dec  = 2'($urandom);
            cnt_load = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00;
            case ($urandom_range(7))
                0, 1: begin
                    address = addr_list[$urandom_range(10)];
                    if (address >= 6'h10 && address < 6'h30) data_in = $urandom_range(5);
                    else if (address == 6'h0C)               data_in = $urandom_range(2);
                    else                                     data_in = $urandom;
                    data_write_n = 2'b10;
                end
                2: begin
                    address      = 6'($urandom);
                    data_in      = $urandom;
                    data_write_n = 2'b00;
                end
                default: data_write_n = 2'b11;
            endcase
            cycle();
            data_write_n = 2'b11;
            chk("rand_cnt_zero", 32'(cnt_zero), m_zero());
            chk("rand_irq", 32'(user_interrupt), m_irq());
            address = ($urandom_range(3) == 0) ? 6'($urandom) : addr_list[$urandom_range(10)];
            #1;
            chk($sformatf("rand_rd_%0h", address), data_out, m_read(address));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
